// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the ID-stage hazard logic.
//   - Instruction field positions for the rs/rt source operands.
//   - The hard-wired zero register, which can never carry a hazard.
//   - Default latencies and counter width used by hazard_scoreboard.
package cpu_pkg;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam int REG_ZERO = 0;

    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MD_LAT   = 4;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/hazard_countdown.sv
// Loadable down-counter that reports busy while its count is non-zero.
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset, clears the count
//   load_i      load load_val_i (wins over decrement)
//   load_val_i  value to load
//   en_i        decrement enable; the count stops at zero
//   busy_o      count is non-zero
module hazard_countdown #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         busy_o
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign busy_o = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use stalls with a configurable stall
// length, plus a single-entry scoreboard for a multi-cycle mul/div unit.
//   clk_i, rst_n_i        clock / asynchronous active-low reset
//   instruction_i         IF/ID instruction (rs, rt fields)
//   id_uses_rs_i/_rt_i    ID instruction actually reads rs / rt
//   id_ex_rt_addr_i       destination of the instruction in ID/EX
//   id_ex_mem_read_i      ID/EX instruction is a load
//   md_issue_i, md_dst_i  mul/div issued from ID and its destination
//   dmem_busy_i           data memory miss, whole pipeline frozen
//   branch_taken_i        branch resolved taken in ID
//   stall_o               hold PC and IF/ID
//   bubble_o              zero ID/EX control
//   flush_o               squash IF/ID
//   md_busy_o             mul/div result pending
//   stall_count_o         saturating count of stalled cycles
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MD_LAT   = DEF_MD_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       instruction_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_ex_rt_addr_i,
    input  logic              id_ex_mem_read_i,
    input  logic              md_issue_i,
    input  logic [REG_AW-1:0] md_dst_i,
    input  logic              dmem_busy_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_o,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam int LW = $clog2(LOAD_LAT + 1);
    localparam int MW = $clog2(MD_LAT + 1);

    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] md_dst;
    logic              lu;
    logic              lu_hold;
    logic              md_pending;
    logic              md_data_hz;
    logic              md_struct_hz;
    logic              hz;
    logic              md_accept;
    logic              unused_instr_bits;

    // True when the ID instruction reads register a; register 0 never matches.
    function automatic logic id_reads(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rt,
                                      input logic              use_rs,
                                      input logic              use_rt);
        return (a != REG_AW'(REG_ZERO)) &&
               ((use_rs && (rs == a)) || (use_rt && (rt == a)));
    endfunction

    assign rs_addr = REG_AW'(instruction_i[RS_MSB:RS_LSB]);
    assign rt_addr = REG_AW'(instruction_i[RT_MSB:RT_LSB]);
    assign unused_instr_bits = ^{instruction_i[31:26], instruction_i[15:0]};

    assign lu = id_ex_mem_read_i &&
                id_reads(id_ex_rt_addr_i, rs_addr, rt_addr, id_uses_rs_i, id_uses_rt_i);

    assign md_data_hz = md_pending &&
                        id_reads(md_dst, rs_addr, rt_addr, id_uses_rs_i, id_uses_rt_i);
    assign md_struct_hz = md_issue_i && md_pending;

    assign hz        = lu || lu_hold || md_data_hz || md_struct_hz;
    assign stall_o   = hz || dmem_busy_i;
    // During a memory freeze every stage holds, so nothing may be bubbled.
    assign bubble_o  = hz && !dmem_busy_i;
    assign flush_o   = branch_taken_i && !stall_o;
    assign md_busy_o = md_pending;
    assign md_accept = md_issue_i && !stall_o;

    // The hazard cycle itself is the first stall cycle; the counter supplies
    // the remaining LOAD_LAT-1, paused while memory is frozen.
    hazard_countdown #(.W(LW)) u_load_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (lu),
        .load_val_i (LW'(LOAD_LAT - 1)),
        .en_i       (!dmem_busy_i),
        .busy_o     (lu_hold)
    );

    // The mul/div unit runs independently of the pipeline, so it always counts.
    hazard_countdown #(.W(MW)) u_md_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (md_accept),
        .load_val_i (MW'(MD_LAT)),
        .en_i       (1'b1),
        .busy_o     (md_pending)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            md_dst <= '0;
        end else if (md_accept) begin
            md_dst <= md_dst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_count_o <= '0;
        end else if (stall_o && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share all inputs:
//   dut_a: LOAD_LAT=3, MD_LAT=4, CNT_W=16
//   dut_b: LOAD_LAT=1, MD_LAT=4, CNT_W=4 (small counter to reach saturation)
// Output nibbles are {stall, bubble, flush, md_busy}.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] instruction_i;
    logic        id_uses_rs_i;
    logic        id_uses_rt_i;
    logic [4:0]  id_ex_rt_addr_i;
    logic        id_ex_mem_read_i;
    logic        md_issue_i;
    logic [4:0]  md_dst_i;
    logic        dmem_busy_i;
    logic        branch_taken_i;

    logic        a_stall, a_bubble, a_flush, a_md;
    logic [15:0] a_cnt;
    logic        b_stall, b_bubble, b_flush, b_md;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(16)) dut_a (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .instruction_i    (instruction_i),
        .id_uses_rs_i     (id_uses_rs_i),
        .id_uses_rt_i     (id_uses_rt_i),
        .id_ex_rt_addr_i  (id_ex_rt_addr_i),
        .id_ex_mem_read_i (id_ex_mem_read_i),
        .md_issue_i       (md_issue_i),
        .md_dst_i         (md_dst_i),
        .dmem_busy_i      (dmem_busy_i),
        .branch_taken_i   (branch_taken_i),
        .stall_o          (a_stall),
        .bubble_o         (a_bubble),
        .flush_o          (a_flush),
        .md_busy_o        (a_md),
        .stall_count_o    (a_cnt)
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(4)) dut_b (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .instruction_i    (instruction_i),
        .id_uses_rs_i     (id_uses_rs_i),
        .id_uses_rt_i     (id_uses_rt_i),
        .id_ex_rt_addr_i  (id_ex_rt_addr_i),
        .id_ex_mem_read_i (id_ex_mem_read_i),
        .md_issue_i       (md_issue_i),
        .md_dst_i         (md_dst_i),
        .dmem_busy_i      (dmem_busy_i),
        .branch_taken_i   (branch_taken_i),
        .stall_o          (b_stall),
        .bubble_o         (b_bubble),
        .flush_o          (b_flush),
        .md_busy_o        (b_md),
        .stall_count_o    (b_cnt)
    );

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b0, rs, rt, 16'h0};
    endfunction

    task automatic idle();
        instruction_i    = mk(5'd1, 5'd2);
        id_uses_rs_i     = 1'b0;
        id_uses_rt_i     = 1'b0;
        id_ex_rt_addr_i  = 5'd0;
        id_ex_mem_read_i = 1'b0;
        md_issue_i       = 1'b0;
        md_dst_i         = 5'd0;
        dmem_busy_i      = 1'b0;
        branch_taken_i   = 1'b0;
    endtask

    task automatic check_pop();
        exp_t e;
        logic [3:0] oa;
        logic [3:0] ob;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oa = {a_stall, a_bubble, a_flush, a_md};
            ob = {b_stall, b_bubble, b_flush, b_md};
            checks++;
            assert (oa === e.a) else begin
                errors++;
                $error("FAIL %s dut_a observed=%b expected=%b", e.tag, oa, e.a);
            end
            checks++;
            assert (ob === e.b) else begin
                errors++;
                $error("FAIL %s dut_b observed=%b expected=%b", e.tag, ob, e.b);
            end
        end
    endtask

    // Inputs are already driven; compare outputs 1 time unit later.
    task automatic expect_now(input string tag, input logic [3:0] ea, input logic [3:0] eb);
        exp_q.push_back('{tag, ea, eb});
        #1;
        check_pop();
    endtask

    // Compare this cycle's outputs, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] ea, input logic [3:0] eb);
        expect_now(tag, ea, eb);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] ea, input logic [3:0] eb);
        checks++;
        assert (a_cnt === ea) else begin
            errors++;
            $error("FAIL %s dut_a count observed=%0d expected=%0d", tag, a_cnt, ea);
        end
        checks++;
        assert (b_cnt === eb) else begin
            errors++;
            $error("FAIL %s dut_b count observed=%0d expected=%0d", tag, b_cnt, eb);
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n_i = 1'b0;
        #3;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_use(input logic [4:0] addr);
        id_ex_mem_read_i = 1'b1;
        id_ex_rt_addr_i  = addr;
        instruction_i    = mk(addr, 5'd2);
        id_uses_rs_i     = 1'b1;
    endtask

    initial begin
        idle();
        rst_n_i = 1'b0;
        #2;
        expect_now("reset", 4'b0000, 4'b0000);
        check_cnt("reset_cnt", 16'd0, 4'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Load-use on rs: A stalls 3 cycles, B stalls 1.
        load_use(5'd8);
        cyc("lu_c0", 4'b1100, 4'b1100);
        id_ex_mem_read_i = 1'b0;
        cyc("lu_c1", 4'b1100, 4'b0000);
        cyc("lu_c2", 4'b1100, 4'b0000);
        cyc("lu_c3", 4'b0000, 4'b0000);
        check_cnt("lu_cnt", 16'd3, 4'd1);

        // Register 0 and non-read operands never hazard.
        load_use(5'd0);
        cyc("lu_zero", 4'b0000, 4'b0000);
        load_use(5'd8);
        id_uses_rs_i = 1'b0;
        cyc("lu_no_use", 4'b0000, 4'b0000);
        // rt operand match.
        id_ex_rt_addr_i = 5'd5;
        instruction_i   = mk(5'd1, 5'd5);
        id_uses_rt_i    = 1'b1;
        cyc("lu_rt", 4'b1100, 4'b1100);
        idle();
        cyc("lu_rt_h1", 4'b1100, 4'b0000);
        cyc("lu_rt_h2", 4'b1100, 4'b0000);
        cyc("lu_rt_end", 4'b0000, 4'b0000);

        // Mul/div data hazard.
        do_reset();
        md_issue_i = 1'b1;
        md_dst_i   = 5'd9;
        cyc("md_issue", 4'b0000, 4'b0000);
        md_issue_i   = 1'b0;
        instruction_i = mk(5'd1, 5'd9);
        id_uses_rt_i = 1'b1;
        cyc("md_data1", 4'b1101, 4'b1101);
        cyc("md_data2", 4'b1101, 4'b1101);
        cyc("md_data3", 4'b1101, 4'b1101);
        cyc("md_data4", 4'b1101, 4'b1101);
        cyc("md_done", 4'b0000, 4'b0000);

        // Structural hazard: second issue waits until the first completes.
        idle();
        md_issue_i = 1'b1;
        md_dst_i   = 5'd3;
        cyc("md_first", 4'b0000, 4'b0000);
        md_dst_i = 5'd4;
        cyc("md_struct1", 4'b1101, 4'b1101);
        cyc("md_struct2", 4'b1101, 4'b1101);
        cyc("md_struct3", 4'b1101, 4'b1101);
        cyc("md_struct4", 4'b1101, 4'b1101);
        cyc("md_second", 4'b0000, 4'b0000);
        md_issue_i = 1'b0;
        cyc("md_second_busy", 4'b0001, 4'b0001);

        // Memory freeze during a load stall; mul/div keeps counting.
        do_reset();
        md_issue_i = 1'b1;
        md_dst_i   = 5'd20;
        cyc("fz_md_issue", 4'b0000, 4'b0000);
        md_issue_i = 1'b0;
        load_use(5'd8);
        cyc("fz_lu", 4'b1101, 4'b1101);
        id_ex_mem_read_i = 1'b0;
        dmem_busy_i      = 1'b1;
        cyc("fz_1", 4'b1001, 4'b1001);
        cyc("fz_2", 4'b1001, 4'b1001);
        cyc("fz_3", 4'b1001, 4'b1001);
        cyc("fz_4", 4'b1000, 4'b1000);
        cyc("fz_5", 4'b1000, 4'b1000);
        dmem_busy_i = 1'b0;
        cyc("fz_resume1", 4'b1100, 4'b0000);
        cyc("fz_resume2", 4'b1100, 4'b0000);
        cyc("fz_end", 4'b0000, 4'b0000);

        // Branch flush, and flush held off by a stall.
        do_reset();
        branch_taken_i = 1'b1;
        cyc("br_free", 4'b0010, 4'b0010);
        load_use(5'd8);
        cyc("br_lu", 4'b1100, 4'b1100);
        id_ex_mem_read_i = 1'b0;
        cyc("br_hold1", 4'b1100, 4'b0010);
        cyc("br_hold2", 4'b1100, 4'b0010);
        cyc("br_release", 4'b0010, 4'b0010);

        // Asynchronous reset in the middle of mul/div and load stalls.
        do_reset();
        md_issue_i = 1'b1;
        md_dst_i   = 5'd9;
        cyc("rst_md_issue", 4'b0000, 4'b0000);
        md_issue_i = 1'b0;
        load_use(5'd8);
        cyc("rst_lu", 4'b1101, 4'b1101);
        idle();
        expect_now("rst_pending", 4'b1101, 4'b0001);
        check_cnt("rst_pre_cnt", 16'd1, 4'd1);
        rst_n_i = 1'b0;
        expect_now("rst_async", 4'b0000, 4'b0000);
        check_cnt("rst_async_cnt", 16'd0, 4'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc("rst_after", 4'b0000, 4'b0000);

        // Saturation of the 4-bit counter.
        do_reset();
        dmem_busy_i = 1'b1;
        repeat (15) @(posedge clk_i);
        #1;
        check_cnt("sat_15", 16'd15, 4'd15);
        repeat (3) @(posedge clk_i);
        #1;
        check_cnt("sat_18", 16'd18, 4'd15);
        dmem_busy_i = 1'b0;
        @(posedge clk_i);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
